dso_cmd_parser: RTL and testbench

Byte-stream command parser that sits directly upstream of the DSO register file. It turns framed command bytes from the host link (UART/SPI byte receiver) into single-cycle register writes on the `dso_regw` write port (`addr`/`din`/`we`). It also performs register reads through the `dso_regr` read mux. Every completed command produces one response byte back to the host link over a valid/ready handshake.

---
 rtl/dso_cmd_parser.sv | 124 ++++++++++++
 tb/tb_dso_cmd_parser.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dso_cmd_parser.sv
// dso_cmd_parser: turns framed host bytes into dso register writes/reads.
// Write frame: header {SYNC, 1'b1, addr} then one data byte -> one-cycle reg_we, ACK response.
// Read frame:  header {SYNC, 1'b0, addr} -> reg_dout returned as the response byte.
module dso_cmd_parser #(
    parameter int unsigned TIMEOUT = 1000,  // max cycles waiting for a write data byte (>= 2)
    parameter logic [3:0]  SYNC    = 4'hA,
    parameter logic [7:0]  ACK     = 8'hAC
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [2:0] reg_addr,
    output logic [7:0] reg_din,
    output logic       reg_we,
    input  logic [7:0] reg_dout,
    input  logic       err_clr,
    output logic [7:0] err_cnt
);

    localparam int unsigned   TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StData, StWrite, StRead, StResp} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic [7:0]    txd_q, txd_d;
    logic [7:0]    err_q, err_d;
    logic          err_evt;

    // Next-state, datapath loads and output decode.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        addr_d   = addr_q;
        din_d    = din_q;
        txd_d    = txd_q;
        err_evt  = 1'b0;
        rx_ready = 1'b0;
        reg_we   = 1'b0;
        tx_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    if (rx_data[7:4] == SYNC) begin
                        addr_d  = rx_data[2:0];
                        timer_d = '0;
                        state_d = rx_data[3] ? StData : StRead;
                    end else begin
                        err_evt = 1'b1;
                    end
                end
            end
            StData: begin
                rx_ready = 1'b1;
                // An accept in the timeout cycle wins over the timeout.
                if (rx_valid) begin
                    din_d   = rx_data;
                    state_d = StWrite;
                end else if (timer_q == TLAST) begin
                    err_evt = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWrite: begin
                reg_we  = 1'b1;
                txd_d   = ACK;
                state_d = StResp;
            end
            StRead: begin
                txd_d   = reg_dout;
                state_d = StResp;
            end
            StResp: begin
                tx_valid = 1'b1;
                if (tx_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Clear dominates a coincident error; count saturates at 255.
        err_d = err_q;
        if (err_clr) begin
            err_d = 8'd0;
        end else if (err_evt && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            timer_q <= '0;
            addr_q  <= 3'd0;
            din_q   <= 8'd0;
            txd_q   <= 8'd0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    assign reg_addr = addr_q;
    assign reg_din  = din_q;
    assign tx_data  = txd_q;
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_dso_cmd_parser.sv
// Directed bench for dso_cmd_parser with a behavioural dso register file attached.
module tb_dso_cmd_parser;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] reg_addr;
    logic [7:0] reg_din;
    logic       reg_we;
    logic [7:0] reg_dout;
    logic       err_clr;
    logic [7:0] err_cnt;

    // Register file model with a bench-side preload port.
    logic [7:0] regs [8];
    logic       pl_en;
    logic [2:0] pl_addr;
    logic [7:0] pl_data;

    int total = 0;
    int bad   = 0;

    dso_cmd_parser #(.TIMEOUT(8), .SYNC(4'hA), .ACK(8'hAC)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .reg_addr (reg_addr),
        .reg_din  (reg_din),
        .reg_we   (reg_we),
        .reg_dout (reg_dout),
        .err_clr  (err_clr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_en) regs[pl_addr] <= pl_data;
        else if (reg_we) regs[reg_addr] <= reg_din;
    end

    assign reg_dout = regs[reg_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        // Only prints; counting stays inline at each comparison.
        $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0; rx_valid = 1'b1; rx_data = 8'hAB; tx_ready = 1'b0; err_clr = 1'b0;
        pl_en = 1'b0; pl_addr = 3'd0; pl_data = 8'd0;
        tick(); tick();
        total++; if (rx_ready !== 1'b1) begin bad++; chk("rst_rx_ready", {7'd0, rx_ready}, 8'd1); end
        total++; if (tx_valid !== 1'b0) begin bad++; chk("rst_tx_valid", {7'd0, tx_valid}, 8'd0); end
        total++; if (reg_we !== 1'b0) begin bad++; chk("rst_reg_we", {7'd0, reg_we}, 8'd0); end
        total++; if (tx_data !== 8'h00) begin bad++; chk("rst_tx_data", tx_data, 8'h00); end
        total++; if (reg_addr !== 3'd0) begin bad++; chk("rst_reg_addr", {5'd0, reg_addr}, 8'd0); end
        total++; if (reg_din !== 8'h00) begin bad++; chk("rst_reg_din", reg_din, 8'h00); end
        total++; if (err_cnt !== 8'h00) begin bad++; chk("rst_err_cnt", err_cnt, 8'h00); end
        rx_valid = 1'b0;
        nrst = 1'b1;
        tick();
        // A header offered during reset must not have been captured.
        total++; if (rx_ready !== 1'b1) begin bad++; chk("post_rst_idle", {7'd0, rx_ready}, 8'd1); end
        total++; if (reg_addr !== 3'd0) begin bad++; chk("post_rst_addr", {5'd0, reg_addr}, 8'd0); end
    endtask

    task automatic test_write();
        rx_valid = 1'b1; rx_data = 8'hAB;
        tick();
        rx_data = 8'h3C;
        total++; if (reg_addr !== 3'd3) begin bad++; chk("wr_hdr_addr", {5'd0, reg_addr}, 8'd3); end
        total++; if (rx_ready !== 1'b1) begin bad++; chk("wr_data_rx_ready", {7'd0, rx_ready}, 8'd1); end
        tick();
        rx_valid = 1'b0;
        total++; if (reg_we !== 1'b1) begin bad++; chk("wr_we_pulse", {7'd0, reg_we}, 8'd1); end
        total++; if (reg_din !== 8'h3C) begin bad++; chk("wr_din", reg_din, 8'h3C); end
        total++; if (rx_ready !== 1'b0) begin bad++; chk("wr_rx_ready", {7'd0, rx_ready}, 8'd0); end
        total++; if (tx_valid !== 1'b0) begin bad++; chk("wr_tx_early", {7'd0, tx_valid}, 8'd0); end
        tick();
        total++; if (reg_we !== 1'b0) begin bad++; chk("wr_we_one_cycle", {7'd0, reg_we}, 8'd0); end
        total++; if (regs[3] !== 8'h3C) begin bad++; chk("wr_reg3", regs[3], 8'h3C); end
        total++; if (tx_valid !== 1'b1) begin bad++; chk("wr_tx_valid", {7'd0, tx_valid}, 8'd1); end
        total++; if (tx_data !== 8'hAC) begin bad++; chk("wr_ack", tx_data, 8'hAC); end
        total++; if (err_cnt !== 8'd0) begin bad++; chk("wr_err_cnt", err_cnt, 8'd0); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        total++; if (tx_valid !== 1'b0) begin bad++; chk("wr_tx_done", {7'd0, tx_valid}, 8'd0); end
    endtask

    task automatic test_read_stall();
        logic we_seen;
        preload(3'd5, 8'h77);
        rx_valid = 1'b1; rx_data = 8'hA5;
        tick();
        rx_valid = 1'b0;
        total++; if (reg_addr !== 3'd5) begin bad++; chk("rd_addr", {5'd0, reg_addr}, 8'd5); end
        total++; if (rx_ready !== 1'b0) begin bad++; chk("rd_rx_ready", {7'd0, rx_ready}, 8'd0); end
        we_seen = reg_we;
        tick();
        total++; if (tx_valid !== 1'b1) begin bad++; chk("rd_tx_valid", {7'd0, tx_valid}, 8'd1); end
        total++; if (tx_data !== 8'h77) begin bad++; chk("rd_tx_data", tx_data, 8'h77); end
        for (int i = 0; i < 10; i++) begin
            tick();
            we_seen = we_seen | reg_we;
            total++;
            if (tx_data !== 8'h77 || rx_ready !== 1'b0 || tx_valid !== 1'b1) begin
                bad++; $display("FAIL rd_stall[%0d]: got tx_data=%h rx_ready=%b tx_valid=%b want 77/0/1",
                                 i, tx_data, rx_ready, tx_valid);
            end
        end
        total++; if (we_seen !== 1'b0) begin bad++; chk("rd_no_we", {7'd0, we_seen}, 8'd0); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        // Back-to-back: IDLE right after the response transfer.
        total++; if (rx_ready !== 1'b1) begin bad++; chk("rd_back_to_back", {7'd0, rx_ready}, 8'd1); end
    endtask

    task automatic test_bad_sync();
        rx_valid = 1'b1; rx_data = 8'h3F;
        tick();
        rx_valid = 1'b0;
        total++; if (err_cnt !== 8'd1) begin bad++; chk("bs_err_cnt", err_cnt, 8'd1); end
        total++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin
            bad++; chk("bs_stays_idle", {6'd0, rx_ready, tx_valid}, 8'h02); end
        total++; if (reg_addr !== 3'd5) begin bad++; chk("bs_addr_held", {5'd0, reg_addr}, 8'd5); end
        rx_valid = 1'b1; rx_data = 8'hA9;
        tick();
        rx_data = 8'h01;
        tick();
        rx_valid = 1'b0;
        total++; if (reg_we !== 1'b1 || reg_addr !== 3'd1) begin
            bad++; chk("bs_wr1_we_addr", {reg_we, 4'd0, reg_addr}, 8'h81); end
        tick();
        total++; if (regs[1] !== 8'h01) begin bad++; chk("bs_reg1", regs[1], 8'h01); end
        total++; if (tx_data !== 8'hAC) begin bad++; chk("bs_ack", tx_data, 8'hAC); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_timeout();
        logic we_seen;
        // Data byte in the 8th DATA cycle is still accepted.
        rx_valid = 1'b1; rx_data = 8'hAA;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        total++; if (err_cnt !== 8'd1) begin bad++; chk("to_late_err", err_cnt, 8'd1); end
        rx_valid = 1'b1; rx_data = 8'h5A;
        tick();
        rx_valid = 1'b0;
        total++; if (reg_we !== 1'b1 || reg_din !== 8'h5A || reg_addr !== 3'd2) begin
            bad++; $display("FAIL to_late_write: got we=%b din=%h addr=%0d want 1/5a/2",
                             reg_we, reg_din, reg_addr);
        end
        tick();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        total++; if (regs[2] !== 8'h5A) begin bad++; chk("to_late_reg2", regs[2], 8'h5A); end
        // No data byte: after 8 DATA cycles the frame is dropped.
        rx_valid = 1'b1; rx_data = 8'hAA;
        tick();
        rx_valid = 1'b0;
        we_seen = 1'b0;
        for (int i = 0; i < 7; i++) begin tick(); we_seen = we_seen | reg_we; end
        total++; if (err_cnt !== 8'd1) begin bad++; chk("to_not_yet", err_cnt, 8'd1); end
        tick();
        we_seen = we_seen | reg_we;
        total++; if (err_cnt !== 8'd2) begin bad++; chk("to_err_cnt", err_cnt, 8'd2); end
        total++; if (we_seen !== 1'b0) begin bad++; chk("to_no_we", {7'd0, we_seen}, 8'd0); end
        // Back in IDLE: a read header is treated as a header, not data.
        rx_valid = 1'b1; rx_data = 8'hA2;
        tick();
        rx_valid = 1'b0;
        total++; if (reg_we !== 1'b0 || rx_ready !== 1'b0) begin
            bad++; chk("to_idle_read", {6'd0, reg_we, rx_ready}, 8'd0); end
        tick();
        total++; if (tx_data !== 8'h5A) begin bad++; chk("to_read_back", tx_data, 8'h5A); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic test_err_sat();
        rx_valid = 1'b1; rx_data = 8'h3F;
        for (int i = 0; i < 300; i++) tick();
        total++; if (err_cnt !== 8'd255) begin bad++; chk("sat_255", err_cnt, 8'd255); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0; rx_valid = 1'b0;
        total++; if (err_cnt !== 8'd0) begin bad++; chk("clr_with_err", err_cnt, 8'd0); end
    endtask

    task automatic test_reset_mid();
        logic we_seen;
        preload(3'd6, 8'h99);
        preload(3'd4, 8'h12);
        // Reset between header and data byte.
        rx_valid = 1'b1; rx_data = 8'hAE;
        tick();
        rx_data = 8'h11;
        #2 nrst = 1'b0;
        #1;
        total++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || reg_we !== 1'b0) begin
            bad++; chk("rm_ctrl", {5'd0, rx_ready, tx_valid, reg_we}, 8'h04); end
        total++; if (reg_addr !== 3'd0 || reg_din !== 8'd0 || tx_data !== 8'd0) begin
            bad++; $display("FAIL rm_data: got addr=%0d din=%h tx=%h want 0/00/00",
                             reg_addr, reg_din, tx_data);
        end
        tick();
        rx_valid = 1'b0;
        nrst = 1'b1;
        we_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); we_seen = we_seen | reg_we; end
        total++; if (we_seen !== 1'b0) begin bad++; chk("rm_no_write", {7'd0, we_seen}, 8'd0); end
        total++; if (regs[6] !== 8'h99) begin bad++; chk("rm_reg6_kept", regs[6], 8'h99); end
        rx_valid = 1'b1; rx_data = 8'hA6;
        tick();
        rx_valid = 1'b0;
        tick();
        total++; if (tx_data !== 8'h99) begin bad++; chk("rm_read_back", tx_data, 8'h99); end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        // Reset while in WRITE: strobe drops at once, register untouched.
        rx_valid = 1'b1; rx_data = 8'hAC;
        tick();
        rx_data = 8'h44;
        tick();
        rx_valid = 1'b0;
        nrst = 1'b0;
        #1;
        total++; if (reg_we !== 1'b0) begin bad++; chk("rm_we_drop", {7'd0, reg_we}, 8'd0); end
        tick();
        nrst = 1'b1;
        tick();
        total++; if (regs[4] !== 8'h12) begin bad++; chk("rm_reg4_kept", regs[4], 8'h12); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_stall();
        test_bad_sync();
        test_timeout();
        test_err_sat();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
